// File: rtl/axi_master_engine_if.sv
// -----------------------------------------------------------------------------
// axi_master_engine_if
// AXI4 bus bundle between axi_master_engine (master modport) and an AXI slave
// or interconnect port (slave modport).
//   AW: awaddr, awlen, awsize, awburst, awvalid / awready
//   W : wdata, wstrb, wlast, wvalid / wready
//   B : bresp, bvalid / bready
//   AR: arid, araddr, arlen, arsize, arburst, arvalid / arready
//   R : rdata, rresp, rlast, rvalid / rready
// awsize/arsize are the standard 3-bit AXI size fields.
// -----------------------------------------------------------------------------
interface axi_master_engine_if #(
   parameter int addr_wid_axi = 32,
   parameter int data_wid     = 32
);
   localparam int STRB_W = data_wid / 8;

   logic [addr_wid_axi-1:0] awaddr;
   logic [7:0]              awlen;
   logic [2:0]              awsize;
   logic [1:0]              awburst;
   logic                    awvalid;
   logic                    awready;

   logic [data_wid-1:0]     wdata;
   logic [STRB_W-1:0]       wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;

   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;

   logic [1:0]              arid;
   logic [addr_wid_axi-1:0] araddr;
   logic [7:0]              arlen;
   logic [2:0]              arsize;
   logic [1:0]              arburst;
   logic                    arvalid;
   logic                    arready;

   logic [data_wid-1:0]     rdata;
   logic [1:0]              rresp;
   logic                    rlast;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi_master_engine.sv
// -----------------------------------------------------------------------------
// axi_master_engine
// Single-outstanding AXI4 initiator. One local command becomes one AXI burst:
// writes run AW -> W beats -> B, reads run AR -> R beats. Completion is a
// one-cycle done pulse with a 2-bit status (AXI response code, 10 for an
// illegal command or a mis-framed read burst, 11 for a watchdog expiry).
//
// Ports
//   aclk, areset              clock, synchronous active-high reset
//   cmd_*                     command port (valid/ready), write/addr/len/burst
//   wr_data/strb/valid/ready  local write-beat source, passed to the W channel
//   rd_data/resp/last/valid,
//   rd_ready                  local read-beat sink, passed from the R channel
//   done, status              completion pulse and response code
//   m_axi                     AXI4 bus (axi_master_engine_if.master)
//
// Optional build macro: AXI_MASTER_TIMEOUT_EN adds a per-handshake watchdog of
// TIMEOUT_CYCLES cycles. Without it the engine waits indefinitely.
// -----------------------------------------------------------------------------
module axi_master_engine #(
   parameter int addr_wid_axi   = 32,
   parameter int data_wid       = 32,
   parameter int asize          = $clog2(data_wid / 8),
   parameter int stroblen       = data_wid / 8,
   parameter int ARID_VAL       = 0,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [addr_wid_axi-1:0] cmd_addr,
   input  logic [7:0]              cmd_len,
   input  logic [1:0]              cmd_burst,
   input  logic [data_wid-1:0]     wr_data,
   input  logic [stroblen-1:0]     wr_strb,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   output logic [data_wid-1:0]     rd_data,
   output logic [1:0]              rd_resp,
   output logic                    rd_last,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic                    done,
   output logic [1:0]              status,
   axi_master_engine_if.master     m_axi
);

   typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, FIN} state_t;

   state_t                  r_state, w_state_next;
   logic [addr_wid_axi-1:0] r_addr;
   logic [7:0]              r_len, r_cnt, w_cnt_next;
   logic [1:0]              r_burst, r_status, w_status_next;
   logic                    w_illegal, w_tmo, w_at_last;
   logic                    w_awvalid, w_wvalid, w_bready, w_arvalid, w_rready;

   // WRAP bursts are only defined for 2, 4, 8 or 16 beats; burst code 11 is reserved.
   assign w_illegal = (cmd_burst == 2'b11) ||
                      ((cmd_burst == 2'b10) && !(cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15}));
   assign w_at_last = (r_cnt == r_len);

`ifdef AXI_MASTER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] r_tmo;
   logic             w_busy, w_hs;

   // Handshake terms use raw inputs so the watchdog does not loop through the valids it gates.
   always_comb begin
      w_busy = 1'b1;
      w_hs   = 1'b0;
      case (r_state)
         WADDR:   w_hs = m_axi.awready;
         WDATA:   w_hs = wr_valid & m_axi.wready;
         WRESP:   w_hs = m_axi.bvalid;
         RADDR:   w_hs = m_axi.arready;
         RDATA:   w_hs = m_axi.rvalid & rd_ready;
         default: w_busy = 1'b0;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset || !w_busy || w_hs) r_tmo <= '0;
      else                           r_tmo <= r_tmo + 1'b1;
   end

   // Fires in the limit-th waiting cycle; FIN follows on the next edge.
   assign w_tmo = w_busy && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`else
   // Watchdog compiled out: this term is false for every legal limit.
   assign w_tmo = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_len    <= '0;
         r_burst  <= '0;
         r_cnt    <= '0;
         r_status <= '0;
      end else begin
         r_state  <= w_state_next;
         r_cnt    <= w_cnt_next;
         r_status <= w_status_next;
         if (cmd_valid && cmd_ready) begin
            r_addr  <= cmd_addr;
            r_len   <= cmd_len;
            r_burst <= cmd_burst;
         end
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_status_next = r_status;
      cmd_ready     = 1'b0;
      wr_ready      = 1'b0;
      rd_valid      = 1'b0;
      done          = 1'b0;
      w_awvalid     = 1'b0;
      w_wvalid      = 1'b0;
      w_bready      = 1'b0;
      w_arvalid     = 1'b0;
      w_rready      = 1'b0;
      case (r_state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               w_cnt_next    = '0;
               w_status_next = 2'b00;
               if (w_illegal) begin
                  w_status_next = 2'b10;
                  w_state_next  = FIN;
               end else begin
                  w_state_next = cmd_write ? WADDR : RADDR;
               end
            end
         end
         WADDR: begin
            w_awvalid = !w_tmo;
            if (w_tmo) begin
               w_status_next = 2'b11;
               w_state_next  = FIN;
            end else if (m_axi.awready) begin
               w_state_next = WDATA;
            end
         end
         WDATA: begin
            w_wvalid = wr_valid && !w_tmo;
            wr_ready = m_axi.wready && !w_tmo;
            if (w_tmo) begin
               w_status_next = 2'b11;
               w_state_next  = FIN;
            end else if (wr_valid && m_axi.wready) begin
               w_cnt_next = r_cnt + 8'd1;
               if (w_at_last) w_state_next = WRESP;
            end
         end
         WRESP: begin
            w_bready = !w_tmo;
            if (w_tmo) begin
               w_status_next = 2'b11;
               w_state_next  = FIN;
            end else if (m_axi.bvalid) begin
               w_status_next = m_axi.bresp;
               w_state_next  = FIN;
            end
         end
         RADDR: begin
            w_arvalid = !w_tmo;
            if (w_tmo) begin
               w_status_next = 2'b11;
               w_state_next  = FIN;
            end else if (m_axi.arready) begin
               w_state_next = RDATA;
            end
         end
         RDATA: begin
            w_rready = rd_ready && !w_tmo;
            rd_valid = m_axi.rvalid && !w_tmo;
            if (w_tmo) begin
               w_status_next = 2'b11;
               w_state_next  = FIN;
            end else if (m_axi.rvalid && rd_ready) begin
               w_cnt_next = r_cnt + 8'd1;
               // rlast must coincide with the arlen-th beat; a framing error overrides the response.
               if (m_axi.rlast != w_at_last) w_status_next = 2'b10;
               else if (r_status == 2'b00)   w_status_next = m_axi.rresp;
               if (m_axi.rlast) w_state_next = FIN;
            end
         end
         FIN: begin
            done         = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign m_axi.awaddr  = r_addr;
   assign m_axi.awlen   = r_len;
   assign m_axi.awsize  = 3'(asize);
   assign m_axi.awburst = r_burst;
   assign m_axi.awvalid = w_awvalid;
   assign m_axi.wdata   = wr_data;
   assign m_axi.wstrb   = wr_strb;
   assign m_axi.wlast   = (r_state == WDATA) && w_at_last;
   assign m_axi.wvalid  = w_wvalid;
   assign m_axi.bready  = w_bready;
   assign m_axi.arid    = 2'(ARID_VAL);
   assign m_axi.araddr  = r_addr;
   assign m_axi.arlen   = r_len;
   assign m_axi.arsize  = 3'(asize);
   assign m_axi.arburst = r_burst;
   assign m_axi.arvalid = w_arvalid;
   assign m_axi.rready  = w_rready;

   assign rd_data = m_axi.rdata;
   assign rd_resp = m_axi.rresp;
   assign rd_last = m_axi.rlast;
   assign status  = r_status;

endmodule

// File: tb/tb_axi_master_engine.sv
module tb_axi_master_engine;

   logic        clk = 1'b0;
   logic        areset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [1:0]  cmd_burst;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        wr_valid, wr_ready;
   logic [31:0] rd_data;
   logic [1:0]  rd_resp;
   logic        rd_last, rd_valid, rd_ready;
   logic        done;
   logic [1:0]  status;

   int n_chk  = 0;
   int n_pass = 0;

   axi_master_engine_if #(.addr_wid_axi(32), .data_wid(32)) bus ();

   axi_master_engine #(.addr_wid_axi(32), .data_wid(32), .ARID_VAL(0), .TIMEOUT_CYCLES(16)) dut (
      .aclk(clk), .areset(areset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_burst(cmd_burst),
      .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_resp(rd_resp), .rd_last(rd_last), .rd_valid(rd_valid),
      .rd_ready(rd_ready), .done(done), .status(status), .m_axi(bus)
   );

   always #5 clk = ~clk;

   // One command plus the slave behaviour it meets, and hand-computed results.
   // rresp holds two bits per read beat (beat 0 in [1:0]); beats past 3 answer OKAY.
   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [1:0]  burst;
      int          aw_delay;
      logic        b_en;
      logic [1:0]  bresp;
      logic [7:0]  rresp;
      int          rlast_at;
      logic        rdr_toggle;
      logic [1:0]  exp_status;
      int          exp_done;
      int          exp_beats;
      logic        exp_bus;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic idle_inputs();
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_burst = 0;
      wr_data = 0; wr_strb = 0; wr_valid = 0; rd_ready = 0;
      bus.awready = 0; bus.wready = 0; bus.bresp = 0; bus.bvalid = 0; bus.arready = 0;
      bus.rdata = 0; bus.rresp = 0; bus.rlast = 0; bus.rvalid = 0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int         cyc, done_cyc, beats, viol, aw_seen;
      logic       aw_hs, rd_phase, w_done, any_bus, got_done;
      logic [1:0] st;
      cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len; cmd_burst = v.burst;
      cmd_valid = 1;
      #1;
      chk($sformatf("v%0d cmd_ready", idx), cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 0;
      cyc = 1; done_cyc = -1; beats = 0; viol = 0; aw_seen = 0;
      aw_hs = 0; rd_phase = 0; w_done = 0; any_bus = 0; got_done = 0; st = 0;
      while (!got_done && cyc < 400) begin
         bus.awready = (aw_seen >= v.aw_delay);
         bus.arready = 1;
         bus.wready  = 1;
         wr_valid    = 1;
         wr_data     = 32'hA500_0000 | 32'(beats);
         wr_strb     = 4'hF;
         bus.bvalid  = v.b_en;
         bus.bresp   = v.bresp;
         bus.rvalid  = rd_phase;
         bus.rdata   = 32'h5A00_0000 | 32'(beats);
         bus.rresp   = (beats < 4) ? v.rresp[2*beats +: 2] : 2'b00;
         bus.rlast   = (beats == v.rlast_at);
         rd_ready    = v.rdr_toggle ? cyc[0] : 1'b1;
         #1;
         if (bus.awvalid) begin
            any_bus = 1;
            aw_seen++;
            if (bus.awaddr != v.addr || bus.awlen != v.len || bus.awburst != v.burst || bus.awsize != 3'd2) viol++;
         end
         if (bus.arvalid) begin
            any_bus = 1;
            if (bus.araddr != v.addr || bus.arlen != v.len || bus.arburst != v.burst || bus.arsize != 3'd2 || bus.arid != 2'd0) viol++;
         end
         if (bus.wvalid) begin
            if (!aw_hs || w_done) viol++;
            if (bus.wdata != wr_data || bus.wstrb != wr_strb || !wr_ready) viol++;
            if (bus.wlast != (beats == int'(v.len))) viol++;
         end
         if (rd_phase) begin
            if (bus.rready != rd_ready || rd_valid != bus.rvalid || rd_data != bus.rdata ||
                rd_resp != bus.rresp || rd_last != bus.rlast) viol++;
         end
         if (done) begin
            got_done = 1; done_cyc = cyc; st = status;
            if (cmd_ready) viol++;
         end
         if (bus.awvalid && bus.awready) aw_hs = 1;
         if (bus.wvalid && bus.wready) begin
            beats++;
            if (bus.wlast) w_done = 1;
         end
         if (rd_phase && bus.rvalid && bus.rready) begin
            beats++;
            if (bus.rlast) rd_phase = 0;
         end
         if (bus.arvalid && bus.arready) rd_phase = 1;
         @(posedge clk); #1;
         cyc++;
      end
      chk($sformatf("v%0d done seen", idx), got_done, 1);
      chk($sformatf("v%0d done cycle", idx), done_cyc, v.exp_done);
      chk($sformatf("v%0d status", idx), st, v.exp_status);
      chk($sformatf("v%0d beats", idx), beats, v.exp_beats);
      chk($sformatf("v%0d bus activity", idx), any_bus, v.exp_bus);
      chk($sformatf("v%0d protocol violations", idx), viol, 0);
      chk($sformatf("v%0d done single + back to idle", idx), {done, cmd_ready}, 2'b01);
      idle_inputs();
   endtask

   initial begin
      int   seen;
      logic [7:0] vall;
      idle_inputs();
      areset = 1;

      //                 wr   addr        len     burst  awd  b_en bresp  rresp  rlast  tog   st     done beats bus
      vecs.push_back(vec_t'{1'b1, 32'h100,  8'd3,   2'b01, 0, 1'b1, 2'b00, 8'h00, 0, 1'b0, 2'b00, 7,   4,   1'b1});
      vecs.push_back(vec_t'{1'b1, 32'h40,   8'd0,   2'b00, 5, 1'b1, 2'b10, 8'h00, 0, 1'b0, 2'b10, 9,   1,   1'b1});
      vecs.push_back(vec_t'{1'b0, 32'h200,  8'd1,   2'b01, 0, 1'b1, 2'b00, 8'h08, 1, 1'b1, 2'b10, 6,   2,   1'b1});
      vecs.push_back(vec_t'{1'b1, 32'h300,  8'd0,   2'b11, 0, 1'b1, 2'b00, 8'h00, 0, 1'b0, 2'b10, 1,   0,   1'b0});
      vecs.push_back(vec_t'{1'b0, 32'h400,  8'd2,   2'b10, 0, 1'b1, 2'b00, 8'h00, 2, 1'b0, 2'b10, 1,   0,   1'b0});
      vecs.push_back(vec_t'{1'b0, 32'h500,  8'd3,   2'b10, 0, 1'b1, 2'b00, 8'h00, 3, 1'b0, 2'b00, 6,   4,   1'b1});
      vecs.push_back(vec_t'{1'b0, 32'h600,  8'd2,   2'b01, 0, 1'b1, 2'b00, 8'h00, 1, 1'b0, 2'b10, 4,   2,   1'b1});
      vecs.push_back(vec_t'{1'b0, 32'h700,  8'd0,   2'b01, 0, 1'b1, 2'b00, 8'h01, 0, 1'b0, 2'b01, 3,   1,   1'b1});
      vecs.push_back(vec_t'{1'b1, 32'h1000, 8'd255, 2'b01, 0, 1'b1, 2'b00, 8'h00, 0, 1'b0, 2'b00, 259, 256, 1'b1});
      vecs.push_back(vec_t'{1'b0, 32'h800,  8'd1,   2'b01, 0, 1'b1, 2'b00, 8'h00, 2, 1'b0, 2'b10, 5,   3,   1'b1});
      vecs.push_back(vec_t'{1'b0, 32'h900,  8'd1,   2'b01, 0, 1'b1, 2'b00, 8'h0B, 1, 1'b0, 2'b11, 4,   2,   1'b1});
`ifdef AXI_MASTER_TIMEOUT_EN
      vecs.push_back(vec_t'{1'b1, 32'h80,   8'd0,   2'b01, 0, 1'b0, 2'b00, 8'h00, 0, 1'b0, 2'b11, 19,  1,   1'b1});
`endif

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      vall = {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, rd_valid, wr_ready, done};
      chk("reset valids", vall, 8'h00);
      chk("reset cmd_ready", cmd_ready, 1);
      chk("reset status", status, 2'b00);
      chk("reset awaddr", bus.awaddr, 32'h0);
      chk("reset araddr/len", {bus.araddr, bus.arlen}, 40'h0);
      areset = 0;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         $display("vector %0d: wr=%0b addr=%0h len=%0d burst=%0b", i, vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].burst);
         run_vec(i, vecs[i]);
      end

      // Reset in the middle of a len=7 write: everything drops at once, no done.
      cmd_write = 1; cmd_addr = 32'h300; cmd_len = 8'd7; cmd_burst = 2'b01; cmd_valid = 1;
      bus.awready = 1; bus.wready = 1; wr_valid = 1; wr_strb = 4'hF; rd_ready = 1;
      @(posedge clk); #1;
      cmd_valid = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_mid in WDATA", bus.wvalid, 1);
      areset = 1;
      @(posedge clk); #1;
      vall = {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, rd_valid, wr_ready, done};
      chk("rst_mid valids", vall, 8'h00);
      chk("rst_mid cmd_ready", cmd_ready, 1);
      areset = 0;
      seen = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (done || bus.wvalid || bus.awvalid) seen++;
      end
      chk("rst_mid no done/activity", seen, 0);
      $display("reset-mid sequence complete");
      idle_inputs();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
